// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit,
// ready/data back from memory.
interface fetch_pc_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, addr, input ready, rdata);
   modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// Multi-cycle fetch stage: owns the PC, fetches one word, holds it while the
// instruction executes, then steps to the next PC from the branch code.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fetch_pc_unit_if.master        imem,
   output logic [31:0]            instr,
   output logic [5:0]             opcode,
   output logic [5:0]             funct,
   output logic                   instr_valid,
   output logic [31:0]            pc,
   output logic [31:0]            pc_plus4,
   input  logic [2:0]             desvio,
   input  logic                   alu_zero,
   input  logic [31:0]            jr_target,
   input  logic                   instr_done,
   input  logic                   halt,
   output logic                   halted,
   output logic                   fetch_err,
   output logic                   bad_target
);

   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [31:0] br_target;
   logic [31:0] next_pc;
   logic        next_bad;

   assign pc_plus4    = pc + 32'd4;
   assign br_target   = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign opcode      = instr[31:26];
   assign funct       = instr[5:0];
   assign imem.req    = (state == FETCH);
   assign imem.addr   = pc;
   assign instr_valid = (state == EXEC);
   assign halted      = (state == HALT);

   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      next_pc  = pc_plus4;
      next_bad = 1'b0;
      case (desvio)
         3'b000: ;
         3'b001: if (alu_zero)  next_pc = br_target;
         3'b010: if (!alu_zero) next_pc = br_target;
         3'b011,
         3'b100: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
         3'b101: begin
            next_pc  = {jr_target[31:2], 2'b00};
            next_bad = |jr_target[1:0];
         end
         default: next_bad = 1'b1;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // sees values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         instr      <= '0;
         cnt        <= '0;
         fetch_err  <= 1'b0;
         bad_target <= 1'b0;
      end else begin
         fetch_err  <= 1'b0;
         bad_target <= 1'b0;
         case (state)
            FETCH: begin
               if (imem.ready) begin
                  instr <= imem.rdata;
                  cnt   <= '0;
                  state <= EXEC;
               end else if (cnt == TIMEOUT_LAST) begin
                  // Retry the same address forever; the pulse only reports it.
                  fetch_err <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            EXEC: begin
               if (instr_done) begin
                  pc         <= next_pc;
                  bad_target <= next_bad;
                  state      <= halt ? HALT : FETCH;
               end
            end
            HALT: ;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized
// instructions checked against an arithmetic next-PC model.
module tb_fetch_pc_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr, pc, pc_plus4, jr_target;
   logic [5:0]  opcode, funct;
   logic [2:0]  desvio;
   logic        instr_valid, alu_zero, instr_done, halt, halted, fetch_err, bad_target;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;
   logic [31:0] cur_instr;

   fetch_pc_unit_if imem ();

   fetch_pc_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .imem(imem),
      .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4), .desvio(desvio), .alu_zero(alu_zero),
      .jr_target(jr_target), .instr_done(instr_done), .halt(halt),
      .halted(halted), .fetch_err(fetch_err), .bad_target(bad_target)
   );

   always #5 clk = ~clk;

   // Reference next-PC rules written as plain arithmetic.
   task automatic ref_next(input logic [31:0] cpc, input logic [31:0] ins, input logic [2:0] d,
                           input logic z, input logic [31:0] jr,
                           output logic [31:0] np, output logic bad);
      logic [31:0] seq, br, jmp;
      int imm;
      seq = cpc + 32'd4;
      imm = int'($signed(ins[15:0]));
      br  = seq + 32'(imm * 4);
      jmp = (seq & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4;
      bad = 1'b0;
      case (d)
         3'd0: np = seq;
         3'd1: np = z ? br : seq;
         3'd2: np = z ? seq : br;
         3'd3, 3'd4: np = jmp;
         3'd5: begin np = jr - (jr % 32'd4); bad = (jr % 32'd4) != 0; end
         default: begin np = seq; bad = 1'b1; end
      endcase
   endtask

   task automatic fetch_word(input logic [31:0] word, input int delay, input string tag);
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== exp_pc) begin
         errors++;
         $display("FAIL %s_fetch_req got req=%b addr=%h, want req=1 addr=%h", tag, imem.req, imem.addr, exp_pc);
      end
      for (int i = 0; i < delay; i++) begin @(posedge clk); #1; end
      imem.ready = 1'b1;
      imem.rdata = word;
      @(posedge clk); #1;
      imem.ready = 1'b0;
      imem.rdata = $urandom;
      cur_instr  = word;
      checks++;
      if (instr_valid !== 1'b1 || instr !== word || opcode !== word[31:26] || funct !== word[5:0]) begin
         errors++;
         $display("FAIL %s_latch got v=%b instr=%h op=%h fn=%h, want v=1 instr=%h", tag, instr_valid, instr, opcode, funct, word);
      end
      checks++;
      if (imem.req !== 1'b0 || pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4 || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL %s_exec_state got req=%b pc=%h pc4=%h ferr=%b, want req=0 pc=%h pc4=%h ferr=0", tag, imem.req, pc, pc_plus4, fetch_err, exp_pc, exp_pc + 32'd4);
      end
   endtask

   task automatic exec_word(input logic [2:0] d, input logic z, input logic [31:0] jr,
                            input logic h, input int hold, input string tag);
      logic [31:0] np;
      logic        bad;
      for (int i = 0; i < hold; i++) begin
         desvio = 3'($urandom);
         @(posedge clk); #1;
         checks++;
         if (instr_valid !== 1'b1 || instr !== cur_instr || pc !== exp_pc) begin
            errors++;
            $display("FAIL %s_hold got v=%b instr=%h pc=%h, want v=1 instr=%h pc=%h", tag, instr_valid, instr, pc, cur_instr, exp_pc);
         end
      end
      desvio = d; alu_zero = z; jr_target = jr; halt = h; instr_done = 1'b1;
      ref_next(exp_pc, cur_instr, d, z, jr, np, bad);
      @(posedge clk); #1;
      instr_done = 1'b0; halt = 1'b0;
      exp_pc = np;
      checks++;
      if (pc !== np || bad_target !== bad) begin
         errors++;
         $display("FAIL %s_next_pc got pc=%h bad=%b, want pc=%h bad=%b", tag, pc, bad_target, np, bad);
      end
      checks++;
      if (h ? (halted !== 1'b1 || imem.req !== 1'b0 || instr_valid !== 1'b0)
            : (halted !== 1'b0 || imem.req !== 1'b1 || imem.addr !== np || instr_valid !== 1'b0)) begin
         errors++;
         $display("FAIL %s_after_done got halted=%b req=%b addr=%h v=%b, want halted=%b addr=%h", tag, halted, imem.req, imem.addr, instr_valid, h, np);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      checks++;
      if (pc !== 32'h0 || instr !== 32'h0 || imem.req !== 1'b1 || imem.addr !== 32'h0 ||
          instr_valid !== 1'b0 || halted !== 1'b0 || fetch_err !== 1'b0 || bad_target !== 1'b0) begin
         errors++;
         $display("FAIL reset got pc=%h instr=%h req=%b v=%b halted=%b ferr=%b bad=%b, want pc=0 instr=0 req=1 others 0", pc, instr, imem.req, instr_valid, halted, fetch_err, bad_target);
      end
   endtask

   task automatic test_first_fetch();
      fetch_word(32'h2008_0005, 0, "first");
      checks++;
      if (opcode !== 6'b001000 || funct !== 6'b000101) begin
         errors++;
         $display("FAIL first_decode got op=%b fn=%b, want op=001000 fn=000101", opcode, funct);
      end
      exec_word(3'b000, 1'b0, 32'h0, 1'b0, 1, "first");
      checks++;
      if (imem.addr !== 32'h4) begin
         errors++;
         $display("FAIL first_addr got %h, want 00000004", imem.addr);
      end
   endtask

   task automatic test_branch();
      fetch_word({6'b000010, 26'h4}, 1, "j10");
      exec_word(3'b011, 1'b0, 32'h0, 1'b0, 0, "j10");
      fetch_word(32'h1000_FFFE, 0, "beq_t");
      exec_word(3'b001, 1'b1, 32'h0, 1'b0, 0, "beq_t");
      checks++;
      if (pc !== 32'h0000_000C) begin
         errors++;
         $display("FAIL beq_taken_pc got %h, want 0000000c", pc);
      end
      fetch_word({6'b000010, 26'h4}, 0, "j10b");
      exec_word(3'b011, 1'b0, 32'h0, 1'b0, 0, "j10b");
      fetch_word(32'h1000_FFFE, 2, "beq_n");
      exec_word(3'b001, 1'b0, 32'h0, 1'b0, 0, "beq_n");
      checks++;
      if (pc !== 32'h0000_0014) begin
         errors++;
         $display("FAIL beq_not_taken_pc got %h, want 00000014", pc);
      end
      fetch_word(32'h1400_FFFE, 0, "bne");
      exec_word(3'b010, 1'b0, 32'h0, 1'b0, 0, "bne");
   endtask

   task automatic test_jal();
      fetch_word(32'h0000_0008, 0, "jr_hi");
      exec_word(3'b101, 1'b0, 32'h1000_0000, 1'b0, 0, "jr_hi");
      fetch_word({6'b000011, 26'h0000040}, 0, "jal");
      checks++;
      if (pc_plus4 !== 32'h1000_0004) begin
         errors++;
         $display("FAIL jal_link got %h, want 10000004", pc_plus4);
      end
      exec_word(3'b100, 1'b0, 32'h0, 1'b0, 0, "jal");
      checks++;
      if (pc !== 32'h1000_0100) begin
         errors++;
         $display("FAIL jal_target got %h, want 10000100", pc);
      end
   endtask

   task automatic test_bad_target();
      fetch_word(32'h0000_0008, 0, "jr_mis");
      exec_word(3'b101, 1'b0, 32'h0000_0203, 1'b0, 0, "jr_mis");
      @(posedge clk); #1;
      checks++;
      if (pc !== 32'h0000_0200 || bad_target !== 1'b0) begin
         errors++;
         $display("FAIL jr_mis_pulse got pc=%h bad=%b, want pc=00000200 bad=0", pc, bad_target);
      end
      fetch_word(32'hFFFF_FFFF, 0, "resv");
      exec_word(3'b111, 1'b1, 32'h0, 1'b0, 0, "resv");
      @(posedge clk); #1;
      checks++;
      if (pc !== 32'h0000_0204 || bad_target !== 1'b0) begin
         errors++;
         $display("FAIL resv_pulse got pc=%h bad=%b, want pc=00000204 bad=0", pc, bad_target);
      end
   endtask

   task automatic test_wrap();
      fetch_word(32'h0000_0008, 0, "jr_top");
      exec_word(3'b101, 1'b0, 32'hFFFF_FFFC, 1'b0, 0, "jr_top");
      fetch_word(32'h0000_0000, 0, "wrap");
      checks++;
      if (pc_plus4 !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc_plus4 got %h, want 00000000", pc_plus4);
      end
      exec_word(3'b000, 1'b0, 32'h0, 1'b0, 0, "wrap");
   endtask

   task automatic test_timeout();
      int pulses = 0;
      int drift  = 0;
      logic [31:0] hold_addr;
      hold_addr = imem.addr;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (fetch_err === 1'b1) pulses++;
         if (imem.req !== 1'b1 || imem.addr !== hold_addr) drift++;
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL timeout_pulses got %0d, want 2", pulses);
      end
      checks++;
      if (drift != 0 || hold_addr !== exp_pc) begin
         errors++;
         $display("FAIL timeout_req_held got %0d drifting cycles addr=%h, want 0 addr=%h", drift, hold_addr, exp_pc);
      end
      fetch_word(32'h0000_0000, 0, "after_to");
      exec_word(3'b000, 1'b0, 32'h0, 1'b0, 0, "after_to");
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] ins, jr;
         ins = $urandom;
         jr  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'($urandom);
         fetch_word(ins, $urandom_range(0, 2), "rnd");
         exec_word(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), jr, 1'b0, $urandom_range(0, 2), "rnd");
      end
   endtask

   task automatic test_reset_mid_exec();
      fetch_word(32'h1234_5678, 0, "mid");
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      checks++;
      if (pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || imem.req !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_exec got pc=%h instr=%h v=%b req=%b, want pc=0 instr=0 v=0 req=1", pc, instr, instr_valid, imem.req);
      end
      fetch_word(32'hABCD_0001, 0, "post_rst");
      exec_word(3'b000, 1'b0, 32'h0, 1'b0, 0, "post_rst");
   endtask

   task automatic test_halt();
      int stray = 0;
      logic [31:0] halt_pc;
      fetch_word(32'h0000_000C, 0, "halt");
      exec_word(3'b000, 1'b0, 32'h0, 1'b1, 0, "halt");
      halt_pc = exp_pc;
      imem.ready = 1'b1; instr_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (halted !== 1'b1 || imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== halt_pc) stray++;
      end
      imem.ready = 1'b0; instr_done = 1'b0;
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL halt_sticky got %0d bad cycles, want 0 (pc want %h)", stray, halt_pc);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      checks++;
      if (halted !== 1'b0 || imem.req !== 1'b1 || pc !== 32'h0) begin
         errors++;
         $display("FAIL halt_reset got halted=%b req=%b pc=%h, want halted=0 req=1 pc=0", halted, imem.req, pc);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      imem.ready = 1'b0; imem.rdata = 32'h0;
      desvio = 3'b000; alu_zero = 1'b0; jr_target = 32'h0;
      instr_done = 1'b0; halt = 1'b0;
      exp_pc = 32'h0; cur_instr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_first_fetch();
      test_branch();
      test_jal();
      test_bad_target();
      test_wrap();
      test_timeout();
      test_random();
      test_reset_mid_exec();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
